debug_display_scan: RTL and testbench

Parametrised debug display selector for the lab CPU board. It routes one of NCH WIDTH-bit probe channels (PC, instruction, ALU operands/result, serial data, …) to a registered display output. Channels are chosen by manual select or by a timed auto-scan, and a freeze control holds the view. It sits between the datapath probe taps and the seven-segment/LED display driver.

---
 rtl/debug_display_scan.sv | 135 +++++++++++++
 tb/tb_debug_display_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_display_scan.sv
// Debug display selector: manual select or timed auto-scan over NCH probe channels, with freeze/hold.
// Optional DISP_SNAPSHOT_EN: capture all channels on freeze and browse the captured bank while frozen.
module debug_display_scan #(
  parameter int          WIDTH   = 32,
  parameter int          NCH     = 8,
  parameter int          DWELL   = 50_000_000,
  parameter logic [31:0] ERR_PAT = 32'h3F,
  localparam int         SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   ch_data,
  input  logic [SELW-1:0]        sel,
  input  logic                   auto_en,
  input  logic                   step,
  input  logic                   freeze,
  output logic [WIDTH-1:0]       display,
  output logic [SELW-1:0]        cur_ch,
  output logic                   frozen,
  output logic                   scan_wrap
);

  localparam int                CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0]   CH_LAST  = SELW'(NCH - 1);
  localparam logic [SELW:0]     CH_LIM   = (SELW + 1)'(NCH);
  localparam logic [WIDTH-1:0]  ERR_W    = WIDTH'(ERR_PAT);

  typedef enum logic [1:0] {MANUAL, AUTO, FROZEN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] display_q, display_d;
  logic [SELW-1:0]  cur_ch_q, cur_ch_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  function automatic logic in_range(input logic [SELW-1:0] x);
    return {1'b0, x} < CH_LIM;
  endfunction

  // Wraps only from the last channel; an out-of-range index simply increments.
  function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] x);
    return (x == CH_LAST) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] bank,
                                            input logic [SELW-1:0]      idx);
    logic [WIDTH-1:0] v;
    v = ERR_W;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) v = bank[k*WIDTH +: WIDTH];
    end
    return v;
  endfunction

`ifdef DISP_SNAPSHOT_EN
  logic [NCH*WIDTH-1:0] snap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (state_q != FROZEN && freeze) begin
      snap_q <= ch_data;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    cur_ch_d  = cur_ch_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    if (state_q == FROZEN) begin
      if (!freeze) begin
        cnt_d = '0;
        if (auto_en) begin
          state_d = AUTO;
          if (!in_range(cur_ch_q)) cur_ch_d = '0;
        end else begin
          state_d = MANUAL;
        end
      end
`ifdef DISP_SNAPSHOT_EN
      else begin
        if (!auto_en)  cur_ch_d = sel;
        else if (step) cur_ch_d = next_ch(cur_ch_q);
        display_d = pick(snap_q, cur_ch_d);
      end
`endif
    end else if (freeze) begin
      state_d = FROZEN;
    end else if (auto_en) begin
      state_d = AUTO;
      if (state_q != AUTO) begin
        if (!in_range(cur_ch_q)) cur_ch_d = '0;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST || step) begin
        cur_ch_d = next_ch(cur_ch_q);
        cnt_d    = '0;
        wrap_d   = (cur_ch_q == CH_LAST);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      display_d = pick(ch_data, cur_ch_d);
    end else begin
      state_d   = MANUAL;
      cur_ch_d  = sel;
      cnt_d     = '0;
      display_d = pick(ch_data, sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MANUAL;
      display_q <= '0;
      cur_ch_q  <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      cur_ch_q  <= cur_ch_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
    end
  end

  assign display   = display_q;
  assign cur_ch    = cur_ch_q;
  assign frozen    = (state_q == FROZEN);
  assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_debug_display_scan.sv
// Directed and randomized bench for debug_display_scan against a behavioural model (WIDTH=32, NCH=6, DWELL=4).
module tb_debug_display_scan;
  localparam int          WIDTH = 32;
  localparam int          NCH   = 6;
  localparam int          DWELL = 4;
  localparam int          SELW  = 3;
  localparam logic [31:0] ERR   = 32'h3F;

  localparam int M_MAN = 0;
  localparam int M_AUT = 1;
  localparam int M_FRZ = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [SELW-1:0]      sel;
  logic                 auto_en, step, freeze;
  logic [WIDTH-1:0]     display;
  logic [SELW-1:0]      cur_ch;
  logic                 frozen, scan_wrap;

  logic [31:0] ch   [NCH];
  logic [31:0] snap [NCH];

  int          m_mode, m_ch, m_left;
  logic [31:0] m_disp;
  logic        m_wrap;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NCH; k++) ch_data[k*WIDTH +: WIDTH] = ch[k];
  end

  debug_display_scan #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL), .ERR_PAT(32'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .sel(sel), .auto_en(auto_en),
    .step(step), .freeze(freeze), .display(display), .cur_ch(cur_ch),
    .frozen(frozen), .scan_wrap(scan_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] chan(input int idx);
    return (idx < NCH) ? ch[idx] : ERR;
  endfunction

  task automatic model_reset();
    m_mode = M_MAN; m_ch = 0; m_left = DWELL; m_disp = '0; m_wrap = 1'b0;
    for (int k = 0; k < NCH; k++) snap[k] = '0;
  endtask

  // m_left counts cycles of dwell remaining for the channel on show.
  task automatic model_edge();
    m_wrap = 1'b0;
    if (m_mode == M_FRZ) begin
      if (!freeze) begin
        m_left = DWELL;
        if (auto_en) begin
          m_mode = M_AUT;
          if (m_ch >= NCH) m_ch = 0;
        end else begin
          m_mode = M_MAN;
        end
      end else begin
`ifdef DISP_SNAPSHOT_EN
        if (!auto_en) m_ch = int'(sel);
        else if (step) m_ch = (m_ch == NCH - 1) ? 0 : (m_ch + 1) % 8;
        m_disp = (m_ch < NCH) ? snap[m_ch] : ERR;
`endif
      end
    end else if (freeze) begin
      m_mode = M_FRZ;
      for (int k = 0; k < NCH; k++) snap[k] = ch[k];
    end else if (auto_en) begin
      if (m_mode != M_AUT) begin
        m_mode = M_AUT;
        if (m_ch >= NCH) m_ch = 0;
        m_left = DWELL;
      end else begin
        m_left--;
        if (m_left == 0 || step) begin
          m_wrap = (m_ch == NCH - 1);
          m_ch   = (m_ch + 1) % NCH;
          m_left = DWELL;
        end
      end
      m_disp = chan(m_ch);
    end else begin
      m_mode = M_MAN;
      m_ch   = int'(sel);
      m_disp = chan(m_ch);
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("display", display, m_disp);
    check("cur_ch", 32'(cur_ch), 32'(m_ch));
    check("frozen", 32'(frozen), 32'(m_mode == M_FRZ));
    check("scan_wrap", 32'(scan_wrap), 32'(m_wrap));
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; auto_en = 1'b0; step = 1'b0; freeze = 1'b0;
    for (int k = 0; k < NCH; k++) ch[k] = 32'h1000_0000 + 32'(k);
    model_reset();
    #2;
    check("rst_display", display, 32'h0);
    check("rst_cur_ch", 32'(cur_ch), 32'h0);
    check("rst_frozen", 32'(frozen), 32'h0);
    #1 rst_n = 1'b1;

    // Manual select
    ch[3] = 32'hDEADBEEF; sel = 3'd3;
    cyc();
    check("man_sel3", display, 32'hDEADBEEF);
    sel = 3'd7;
    cyc();
    check("man_sel7", display, 32'h0000003F);
    check("man_sel7_ch", 32'(cur_ch), 32'd7);

    // Auto-scan from channel 0, with a step colliding with terminal count at j=36
    sel = 3'd0;
    cyc();
    auto_en = 1'b1;
    cyc();
    check("auto_entry", 32'(cur_ch), 32'd0);
    for (int j = 1; j <= 38; j++) begin
      step = (j == 36);
      cyc();
      step = 1'b0;
      check("auto_seq", 32'(cur_ch), 32'((j / 4) % 6));
      check("auto_wrap", 32'(scan_wrap), 32'(j == 24));
    end

    // Asynchronous reset mid-scan at channel 3
    #2 rst_n = 1'b0;
    #1;
    check("arst_display", display, 32'h0);
    check("arst_cur_ch", 32'(cur_ch), 32'h0);
    check("arst_frozen", 32'(frozen), 32'h0);
    check("arst_wrap", 32'(scan_wrap), 32'h0);
    model_reset();
    auto_en = 1'b0;
    #1 rst_n = 1'b1;

    // Freeze holds the view; release shows live data one cycle after frozen falls
    sel = 3'd1; ch[1] = 32'h1111_0000;
    cyc();
    check("frz_pre", display, 32'h1111_0000);
    freeze = 1'b1;
    cyc();
    check("frz_flag", 32'(frozen), 32'd1);
    ch[1] = 32'h12345678;
    cyc();
    check("frz_hold", display, 32'h1111_0000);
    freeze = 1'b0;
    cyc();
    check("frz_fall", 32'(frozen), 32'd0);
    cyc();
    check("frz_release", display, 32'h12345678);

    // Snapshot browsing while frozen
    ch[2] = 32'hA5A5A5A5;
    cyc();
    freeze = 1'b1;
    cyc();
    ch[2] = 32'h0;
    cyc();
    sel = 3'd2;
    cyc();
`ifdef DISP_SNAPSHOT_EN
    check("snap_disp", display, 32'hA5A5A5A5);
    check("snap_ch", 32'(cur_ch), 32'd2);
`else
    check("nosnap_disp", display, 32'h12345678);
    check("nosnap_ch", 32'(cur_ch), 32'd1);
`endif
    freeze = 1'b0;
    cyc();
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0)  auto_en = ~auto_en;
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0)  sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0)  ch[$urandom_range(0, NCH - 1)] = $urandom;
      cyc();
    end
    step = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
